// File: rtl/audio_stream_feeder.sv
// audio_stream_feeder: circular PCM sample buffer feeding mini_audio through its
// data / valid_toggle / full handshake, with optional mid-scale silence on underrun.
`timescale 1ns/1ps
module audio_stream_feeder #(
    parameter int unsigned BUF_DEPTH_IN_BITS = 8,
    parameter int unsigned HOLD_CYCLES       = 4,
    parameter logic [31:0] SILENCE           = 32'h80008000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [31:0]                in_data,
    input  logic                       in_we,
    output logic                       in_ready,
    input  logic                       silence_en,
    input  logic                       clear_flags,
    output logic [31:0]                sink_data,
    output logic                       sink_valid_toggle,
    input  logic                       sink_full,
    output logic [BUF_DEPTH_IN_BITS:0] level,
    output logic                       overflow,
    output logic [15:0]                underrun_count
);
    localparam int unsigned AW    = BUF_DEPTH_IN_BITS;
    localparam int unsigned LW    = BUF_DEPTH_IN_BITS + 1;
    localparam int unsigned DEPTH = 1 << BUF_DEPTH_IN_BITS;
    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES);

    localparam logic [LW-1:0]    LEVEL_FULL = LW'(DEPTH);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        HOLD
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0]      mem [DEPTH];
    logic [31:0]      rd_data;
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [CNT_W-1:0] hold_cnt;
    logic             last_from_buf;

    logic             wr_accept;
    logic             rd_take;
    logic             sil_take;
    logic             underrun_hit;
    logic [LW-1:0]    level_next;

    assign wr_accept  = in_we && in_ready;
    assign level_next = level + LW'(wr_accept) - LW'(rd_take);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle decisions; sink_full is only sampled in IDLE
    always_comb begin
        state_next   = state;
        rd_take      = 1'b0;
        sil_take     = 1'b0;
        underrun_hit = 1'b0;
        case (state)
            IDLE: begin
                if (!sink_full) begin
                    if (level != '0) begin
                        rd_take    = 1'b1;
                        state_next = FETCH;
                    end else begin
                        underrun_hit = last_from_buf;
                        if (silence_en) begin
                            sil_take   = 1'b1;
                            state_next = SEND;
                        end
                    end
                end
            end
            FETCH:   state_next = SEND;
            SEND:    state_next = HOLD;
            HOLD: begin
                if (hold_cnt == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Sample RAM with registered read; contents are not reset, pointers are
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wp] <= in_data;
        end
        if (rd_take) begin
            rd_data <= mem[rp];
        end
    end

    // Pointers, fill level and ready
    always_ff @(posedge clk) begin
        if (reset) begin
            wp       <= '0;
            rp       <= '0;
            level    <= '0;
            in_ready <= 1'b1;
        end else begin
            if (wr_accept) begin
                wp <= wp + AW'(1);
            end
            if (rd_take) begin
                rp <= rp + AW'(1);
            end
            level    <= level_next;
            in_ready <= (level_next != LEVEL_FULL);
        end
    end

    // Sink-side data, toggle and hold timer
    always_ff @(posedge clk) begin
        if (reset) begin
            sink_data         <= SILENCE;
            sink_valid_toggle <= 1'b0;
            hold_cnt          <= '0;
        end else begin
            if (sil_take) begin
                sink_data <= SILENCE;
            end else if (state == FETCH) begin
                sink_data <= rd_data;
            end
            if (state == SEND) begin
                sink_valid_toggle <= ~sink_valid_toggle;
                hold_cnt          <= HOLD_LOAD;
            end else if (state == HOLD && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - CNT_W'(1);
            end
        end
    end

    // Status flags; an underrun episode re-arms only after a buffered sample is taken
    always_ff @(posedge clk) begin
        if (reset) begin
            last_from_buf  <= 1'b0;
            overflow       <= 1'b0;
            underrun_count <= '0;
        end else begin
            if (rd_take) begin
                last_from_buf <= 1'b1;
            end else if (underrun_hit) begin
                last_from_buf <= 1'b0;
            end
            if (clear_flags) begin
                overflow <= 1'b0;
            end else if (in_we && !in_ready) begin
                overflow <= 1'b1;
            end
            if (clear_flags) begin
                underrun_count <= '0;
            end else if (underrun_hit && underrun_count != 16'hFFFF) begin
                underrun_count <= underrun_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_audio_stream_feeder.sv
// Self-checking bench for audio_stream_feeder: random samples scored against a
// queue model of what mini_audio should receive, plus directed boundary phases.
`timescale 1ns/1ps
module tb_audio_stream_feeder;
    localparam int unsigned DB    = 8;
    localparam int unsigned DEPTH = 1 << DB;
    localparam int unsigned HOLD  = 4;
    localparam logic [31:0] SIL   = 32'h80008000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_we;
    logic        in_ready;
    logic        silence_en;
    logic        clear_flags;
    logic [31:0] sink_data;
    logic        sink_valid_toggle;
    logic        sink_full;
    logic [DB:0] level;
    logic        overflow;
    logic [15:0] underrun_count;

    audio_stream_feeder #(
        .BUF_DEPTH_IN_BITS(DB),
        .HOLD_CYCLES      (HOLD),
        .SILENCE          (SIL)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .in_data          (in_data),
        .in_we            (in_we),
        .in_ready         (in_ready),
        .silence_en       (silence_en),
        .clear_flags      (clear_flags),
        .sink_data        (sink_data),
        .sink_valid_toggle(sink_valid_toggle),
        .sink_full        (sink_full),
        .level            (level),
        .overflow         (overflow),
        .underrun_count   (underrun_count)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;

    logic [31:0] exp_q[$];
    int unsigned edge_cyc[$];
    logic        mon_en = 1'b0;
    logic        prev_tog = 1'b0;
    logic [31:0] prev_data = '0;
    logic [31:0] held = '0;
    logic [31:0] mon_want;
    int          hold_left = 0;
    int          sil_recent = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
    endtask

    // Model of mini_audio's receive side: every toggle edge delivers one sample
    always @(negedge clk) begin
        if (silence_en === 1'b1) sil_recent = 4;
        else if (sil_recent > 0) sil_recent--;
        if (!mon_en) begin
            hold_left = 0;
        end else if (sink_valid_toggle !== prev_tog) begin
            edge_cyc.push_back(cyc);
            if (exp_q.size() > 0 && sink_data === exp_q[0]) begin
                mon_want = exp_q.pop_front();
            end else if (sil_recent > 0 || exp_q.size() == 0) begin
                mon_want = SIL;
                if (sil_recent == 0) check("spurious_toggle", 32'(1), 32'(0));
            end else begin
                mon_want = exp_q[0];
            end
            check("sink_data", sink_data, mon_want);
            check("setup", prev_data, mon_want);
            held      = mon_want;
            hold_left = HOLD;
        end else if (hold_left > 0) begin
            check("hold", sink_data, held);
            hold_left--;
        end
        prev_tog  = sink_valid_toggle;
        prev_data = sink_data;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_sample(input logic [31:0] d);
        in_data = d;
        in_we   = 1'b1;
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
        step(1);
        in_we = 1'b0;
    endtask

    function automatic logic [31:0] rand_sample();
        logic [31:0] d;
        do d = $urandom; while (d == SIL);
        return d;
    endfunction

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step(1);
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'(0));
        step(HOLD + 6);
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        step(1);
        clear_flags = 1'b0;
    endtask

    task automatic check_gaps(input string tag, input int unsigned from, input int unsigned lo,
                              input int unsigned hi);
        int unsigned bad = 0;
        for (int unsigned i = from + 1; i < edge_cyc.size(); i++) begin
            if (edge_cyc[i] - edge_cyc[i-1] < lo || edge_cyc[i] - edge_cyc[i-1] > hi) bad++;
        end
        check(tag, bad, 32'(0));
    endtask

    initial begin
        int unsigned n0;
        int          t;
        logic        tg;
        logic [31:0] dir [3];

        reset = 1'b1; in_data = '0; in_we = 1'b0; silence_en = 1'b0;
        clear_flags = 1'b0; sink_full = 1'b0;
        step(3);
        reset = 1'b0;
        check("rst_sink_data", sink_data, SIL);
        check("rst_toggle", 32'(sink_valid_toggle), 32'(0));
        check("rst_level", 32'(level), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_overflow", 32'(overflow), 32'(0));
        check("rst_underrun", 32'(underrun_count), 32'(0));
        step(1);
        mon_en = 1'b1;

        // Three directed samples, streaming at full rate
        dir[0] = 32'h12345678; dir[1] = 32'h9ABC0001; dir[2] = 32'h00000000;
        n0 = edge_cyc.size();
        for (int i = 0; i < 3; i++) write_sample(dir[i]);
        wait_drain("drain_directed", 60);
        check("directed_edges", 32'(edge_cyc.size() - n0), 32'(3));
        check_gaps("directed_period", n0, HOLD + 3, HOLD + 3);
        check("directed_level", 32'(level), 32'(0));
        check("directed_underrun", 32'(underrun_count), 32'(1));
        pulse_clear();
        check("clear_underrun", 32'(underrun_count), 32'(0));

        // Fill to capacity with the sink blocked, then one write too many
        sink_full = 1'b1;
        step(2);
        n0 = edge_cyc.size();
        for (int i = 0; i < DEPTH; i++) begin
            write_sample(rand_sample());
            if (i == DEPTH - 2) check("ready_before_full", 32'(in_ready), 32'(1));
        end
        check("ready_at_full", 32'(in_ready), 32'(0));
        check("level_at_full", 32'(level), 32'(DEPTH));
        check("overflow_not_yet", 32'(overflow), 32'(0));
        write_sample(rand_sample());
        step(1);
        check("overflow_set", 32'(overflow), 32'(1));
        check("level_after_ovf", 32'(level), 32'(DEPTH));
        step(20);
        check("no_toggle_when_full", 32'(edge_cyc.size() - n0), 32'(0));

        // Release: full drain across pointer wrap
        sink_full = 1'b0;
        n0 = edge_cyc.size();
        wait_drain("drain_full", DEPTH * (HOLD + 3) + 50);
        check("drain_edges", 32'(edge_cyc.size() - n0), 32'(DEPTH));
        check_gaps("drain_period", n0, HOLD + 3, HOLD + 3);
        check("drain_level", 32'(level), 32'(0));
        check("drain_ready", 32'(in_ready), 32'(1));
        check("drain_underrun", 32'(underrun_count), 32'(1));
        check("overflow_sticky", 32'(overflow), 32'(1));

        // Silence stream, then one buffered sample causes one underrun episode
        pulse_clear();
        check("clear_overflow", 32'(overflow), 32'(0));
        check("clear_underrun2", 32'(underrun_count), 32'(0));
        silence_en = 1'b1;
        step(10);
        n0 = edge_cyc.size();
        t = 0;
        while (edge_cyc.size() < n0 + 5 && t < 80) begin
            step(1);
            t++;
        end
        check("silence_edges", 32'(edge_cyc.size() - n0 >= 5), 32'(1));
        check_gaps("silence_period", n0, HOLD + 2, HOLD + 2);
        check("silence_underrun", 32'(underrun_count), 32'(0));
        step($urandom_range(0, 5));
        write_sample(rand_sample());
        wait_drain("drain_single", 60);
        step(20);
        check("single_underrun", 32'(underrun_count), 32'(1));
        step(30);
        check("underrun_stays", 32'(underrun_count), 32'(1));

        // Silence disabled: line goes quiet, data frozen at mid-scale
        silence_en = 1'b0;
        step(12);
        n0 = edge_cyc.size();
        step(40);
        check("quiet_edges", 32'(edge_cyc.size() - n0), 32'(0));
        check("quiet_data", sink_data, SIL);
        pulse_clear();
        check("quiet_clear_ovf", 32'(overflow), 32'(0));
        check("quiet_clear_urun", 32'(underrun_count), 32'(0));

        // Random traffic with a randomly stalling sink
        silence_en = 1'($urandom_range(0, 1));
        n0 = edge_cyc.size();
        for (int i = 0; i < 500; i++) begin
            sink_full = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) write_sample(rand_sample());
            else step(1);
        end
        sink_full = 1'b0;
        wait_drain("drain_random", DEPTH * (HOLD + 3) + 50);
        check_gaps("random_min_gap", n0, HOLD + 2, 32'hFFFF_FFFF);
        check("random_level", 32'(level), 32'(0));
        check("random_overflow", 32'(overflow), 32'(0));
        silence_en = 1'b0;
        step(12);

        // Reset in the middle of a transfer with samples still buffered
        sink_full = 1'b1;
        step(2);
        for (int i = 0; i < 10; i++) write_sample(rand_sample());
        step(1);
        check("pre_reset_level", 32'(level), 32'(10));
        sink_full = 1'b0;
        tg = sink_valid_toggle;
        t = 0;
        while (sink_valid_toggle === tg && t < 40) begin
            step(1);
            t++;
        end
        check("hold_reached", 32'(t < 40), 32'(1));
        step(1);
        mon_en = 1'b0;
        reset  = 1'b1;
        step(1);
        reset  = 1'b0;
        check("mid_rst_level", 32'(level), 32'(0));
        check("mid_rst_toggle", 32'(sink_valid_toggle), 32'(0));
        check("mid_rst_data", sink_data, SIL);
        check("mid_rst_ready", 32'(in_ready), 32'(1));
        exp_q.delete();
        step(2);
        mon_en = 1'b1;
        n0 = edge_cyc.size();
        write_sample(rand_sample());
        wait_drain("drain_post_reset", 60);
        check("post_reset_edges", 32'(edge_cyc.size() - n0), 32'(1));
        check("post_reset_level", 32'(level), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
